// File: rtl/oam_dma_engine_pkg.sv
// OAM DMA shared definitions: FSM state encoding, OAM/IO constants and the
// source-page mapping helper used when a transfer is started.
// Latency: n/a (declarations only). Backpressure: n/a.
package oam_dma_engine_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_SETUP,
    DMA_READ,
    DMA_LATCH,
    DMA_WRITE,
    DMA_GAP
  } dma_state_t;

  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_DMA_LEN = 160;
  localparam logic [7:0]  IO_DMA_ADDR = 8'h46;

  // E000-FDFF echoes C000-DDFF, so pages E0 and up fold back by 0x20.
  function automatic logic [7:0] map_src_hi(input logic [7:0] src_hi);
    return (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA master: copies XFER_LEN bytes from page {src_hi,00} into OAM at DEST_BASE.
// Latency: start edge to dma_done = 1 + STARTUP_CYCLES + XFER_LEN*BYTE_CYCLES clocks.
// Backpressure: none; the memory port is owned outright while dma_active=1.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   dma_start, dma_src_hi start pulse from the 0xFF46 decode and the written page
//   mem_rdata             read data, valid the cycle after address+OE
//   mem_address/oe/we/wdata  bus drive, all zero outside READ/LATCH/WRITE
//   dma_active            engine owns the bus
//   dma_done              one-cycle completion pulse, coincides with first IDLE cycle
module oam_dma_engine
  import oam_dma_engine_pkg::*;
#(
  parameter int          BYTE_CYCLES    = 4,
  parameter int          XFER_LEN       = OAM_DMA_LEN,
  parameter logic [15:0] DEST_BASE      = OAM_BASE,
  parameter int          STARTUP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_start,
  input  logic [7:0]  dma_src_hi,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_address,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        dma_active,
  output logic        dma_done
);

  // Terminal values for the phase counter and byte index.
  localparam logic [15:0] SETUP_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(BYTE_CYCLES - 4);
  localparam logic [7:0]  IDX_LAST   = 8'(XFER_LEN - 1);

  dma_state_t  state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  byte_q;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DMA_IDLE;
      phase_q <= 16'h0000;
      idx_q   <= 8'h00;
      src_q   <= 8'h00;
      byte_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      done_q  <= done_d;
      // Read data belongs to the address driven in READ; it lands during LATCH.
      if (state_q == DMA_LATCH) begin
        byte_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    src_d       = src_q;
    done_d      = 1'b0;
    mem_address = 16'h0000;
    mem_oe      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;

    case (state_q)
      DMA_IDLE: ;
      DMA_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          state_d = DMA_READ;
          phase_d = 16'h0000;
        end else begin
          phase_d = phase_q + 16'h0001;
        end
      end
      DMA_READ: begin
        mem_address = {src_q, idx_q};
        mem_oe      = 1'b1;
        state_d     = DMA_LATCH;
      end
      DMA_LATCH: begin
        mem_address = {src_q, idx_q};
        mem_oe      = 1'b1;
        state_d     = DMA_WRITE;
      end
      DMA_WRITE: begin
        mem_address = DEST_BASE + {8'h00, idx_q};
        mem_wdata   = byte_q;
        mem_we      = 1'b1;
        state_d     = DMA_GAP;
        phase_d     = 16'h0000;
      end
      DMA_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = 16'h0000;
          if (idx_q == IDX_LAST) begin
            state_d = DMA_IDLE;
            idx_d   = 8'h00;
            done_d  = 1'b1;
          end else begin
            state_d = DMA_READ;
            idx_d   = idx_q + 8'h01;
          end
        end else begin
          phase_d = phase_q + 16'h0001;
        end
      end
      default: state_d = DMA_IDLE;
    endcase

    // A start from any state wins: restart from byte 0, drop the in-flight byte
    // and suppress the completion pulse of the abandoned transfer.
    if (dma_start) begin
      state_d = DMA_SETUP;
      src_d   = map_src_hi(dma_src_hi);
      idx_d   = 8'h00;
      phase_d = 16'h0000;
      done_d  = 1'b0;
    end
  end

  assign dma_active = (state_q != DMA_IDLE);
  assign dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: default instance (160 bytes, 4 clk/byte) plus a
// one-byte, 6 clk/byte instance; a flat memory model serves reads and captures OAM writes.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_oam_dma_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dma_start, start_b;
  logic [7:0]  dma_src_hi, src_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [15:0] addr_a, addr_b;
  logic        oe_a, we_a, oe_b, we_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        active_a, active_b, done_a, done_b;

  oam_dma_engine dut_a (
    .clk(clk), .rst(rst), .dma_start(dma_start), .dma_src_hi(dma_src_hi),
    .mem_rdata(rdata_a), .mem_address(addr_a), .mem_oe(oe_a), .mem_we(we_a),
    .mem_wdata(wdata_a), .dma_active(active_a), .dma_done(done_a)
  );

  oam_dma_engine #(.BYTE_CYCLES(6), .XFER_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .dma_start(start_b), .dma_src_hi(src_b),
    .mem_rdata(rdata_b), .mem_address(addr_b), .mem_oe(oe_b), .mem_we(we_b),
    .mem_wdata(wdata_b), .dma_active(active_b), .dma_done(done_b)
  );

  // Source memory is written only by the stimulus; OAM only by the bus model.
  logic [7:0] src_mem [0:65535];
  logic [7:0] oam_a [0:255];
  logic [7:0] oam_b [0:255];
  int         wr_cnt_b = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory unit model: registered read, OAM writes ignored while in reset.
  always @(posedge clk) begin
    rdata_a <= oe_a ? src_mem[addr_a] : 8'h00;
    rdata_b <= oe_b ? src_mem[addr_b] : 8'h00;
    if (we_a && !rst && addr_a[15:8] == 8'hFE) oam_a[addr_a[7:0]] = wdata_a;
    if (we_b && !rst && addr_b[15:8] == 8'hFE) oam_b[addr_b[7:0]] = wdata_b;
    if (we_b) wr_cnt_b++;
  end

  // Bus monitor for instance A.
  logic [15:0] rd_q [$];
  logic [15:0] wr_last = 16'h0000;
  int          act_cnt = 0;
  logic        prev_oe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      check("oe_we_overlap", 32'(oe_a & we_a), 32'h0);
      if (!active_a) check("idle_bus", {6'b0, addr_a, wdata_a, oe_a, we_a}, 32'h0);
      if (active_a) act_cnt++;
      if (oe_a && !prev_oe) rd_q.push_back(addr_a);
      if (we_a) wr_last = addr_a;
    end
    prev_oe = oe_a;
  end

  logic [7:0] exp_data [0:159];
  logic [7:0] snap [0:255];
  int rd_base, act_base;

  task automatic fill(input logic [7:0] page);
    logic [7:0] b;
    for (int i = 0; i < 160; i++) begin
      b = 8'($urandom);
      src_mem[{page, 8'(i)}] = b;
      exp_data[i] = b;
    end
  endtask

  task automatic start_a(input logic [7:0] s);
    dma_start  = 1'b1;
    dma_src_hi = s;
    rd_base    = rd_q.size();
    act_base   = act_cnt;
  endtask

  task automatic wait_done_a(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) dma_start = 1'b0;
    end while (!done_a && lat < 3000);
    check("done_seen", 32'(done_a), 32'h1);
  endtask

  task automatic verify(input logic [7:0] src_hi, input int lat, input bit chk_act);
    logic [7:0] page;
    page = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    check("latency", lat, 645);
    if (chk_act) check("active_cycles", act_cnt - act_base, 644);
    check("read_count", rd_q.size() - rd_base, 160);
    for (int i = 0; i < 160; i++) begin
      if (rd_base + i < rd_q.size()) check("read_addr", 32'(rd_q[rd_base + i]), 32'({page, 8'(i)}));
      check("oam_data", 32'(oam_a[i]), 32'(exp_data[i]));
    end
    check("last_write", 32'(wr_last), 32'h0000FE9F);
  endtask

  initial begin
    int lat, n, dones;
    logic [15:0] rd_b;
    logic [7:0]  exp_b;

    rst = 1'b1; dma_start = 1'b0; dma_src_hi = 8'h00; start_b = 1'b0; src_b = 8'h00;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_bus_a", {6'b0, addr_a, wdata_a, oe_a, we_a}, 32'h0);
    check("rst_flags_a", {30'b0, active_a, done_a}, 32'h0);
    check("rst_bus_b", {6'b0, addr_b, wdata_b, oe_b, we_b}, 32'h0);
    check("rst_flags_b", {30'b0, active_b, done_b}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed pattern from page C1.
    for (int i = 0; i < 160; i++) begin
      src_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
      exp_data[i] = 8'(i) ^ 8'h5A;
    end
    start_a(8'hC1);
    wait_done_a(lat);
    check("first_read", (rd_q.size() > rd_base) ? 32'(rd_q[rd_base]) : 32'h0, 32'h0000C100);
    verify(8'hC1, lat, 1'b1);

    // Echo page E3 -> C3, started in the done cycle of the previous transfer.
    fill(8'hC3);
    start_a(8'hE3);
    wait_done_a(lat);
    verify(8'hE3, lat, 1'b1);

    // Page 00 source.
    repeat (3) @(negedge clk);
    fill(8'h00);
    start_a(8'h00);
    wait_done_a(lat);
    verify(8'h00, lat, 1'b1);

    // Restart at the write of idx 50 with page D0.
    repeat (3) @(negedge clk);
    fill(8'hC1);
    fill(8'hD0);
    start_a(8'hC1);
    n = 0; dones = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) dma_start = 1'b0;
      dones += 32'(done_a);
    end while (!(we_a && addr_a == 16'hFE32) && n < 2000);
    check("restart_trigger", 32'(we_a && addr_a == 16'hFE32), 32'h1);
    start_a(8'hD0);
    wait_done_a(lat);
    verify(8'hD0, lat, 1'b0);
    dones += 32'(done_a);
    repeat (20) begin
      @(negedge clk);
      dones += 32'(done_a);
    end
    check("done_pulses", dones, 1);

    // Reset during the write of idx 10.
    fill(8'hC2);
    for (int i = 0; i < 256; i++) snap[i] = oam_a[i];
    start_a(8'hC2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) dma_start = 1'b0;
    end while (!(we_a && addr_a == 16'hFE0A) && n < 2000);
    check("reset_trigger", 32'(we_a && addr_a == 16'hFE0A), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bus", {6'b0, addr_a, wdata_a, oe_a, we_a}, 32'h0);
    check("midrst_flags", {30'b0, active_a, done_a}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (i < 10) check("rst_oam_written", 32'(oam_a[i]), 32'(exp_data[i]));
      else        check("rst_oam_kept", 32'(oam_a[i]), 32'(snap[i]));
    end
    repeat (10) @(negedge clk);
    check("post_rst_idle", {30'b0, active_a, done_a}, 32'h0);

    // Single-byte instance with 6 clocks per byte.
    exp_b = src_mem[16'hC500];
    start_b = 1'b1; src_b = 8'hC5;
    n = 0; rd_b = 16'h0000;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start_b = 1'b0;
      if (oe_b) rd_b = addr_b;
    end while (!done_b && n < 200);
    check("b_latency", n, 11);
    check("b_active_in_done", 32'(active_b), 32'h0);
    check("b_read_addr", 32'(rd_b), 32'h0000C500);
    check("b_oam0", 32'(oam_b[0]), 32'(exp_b));
    check("b_write_count", wr_cnt_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
